// File: rtl/dsm_conv_sequencer.sv
// dsm_conv_sequencer: incremental-mode delta-sigma conversion controller with result handshake
module dsm_conv_sequencer #(
  parameter int OUTPUT_BITS = 16,
  parameter int CNT_W = 10,
  parameter int CONV_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   cont,
  input  logic                   stop,
  input  logic [CNT_W-1:0]       osr_in,
  input  logic [OUTPUT_BITS-1:0] filt_z,
  output logic                   filt_rst,
  output logic                   filt_type_dec,
  output logic [OUTPUT_BITS-1:0] result_data,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic                   overrun,
  input  logic                   clr_ovr,
  output logic                   busy,
  output logic [CONV_CNT_W-1:0]  conv_count
);
  typedef enum logic [2:0] {IDLE, CLEAR, INTEG, DUMP, CAPTURE} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, osr_q, osr_clamped;
  logic cap;
  assign filt_type_dec = 1'b0;
  assign busy = state != IDLE;
  assign cap = state == CAPTURE;
  assign osr_clamped = (osr_in < CNT_W'(2)) ? CNT_W'(2) : osr_in;
  always_comb begin
    state_n = state;
    cnt_n = '0;
    case (state)
      IDLE:    state_n = (start && !stop) ? CLEAR : IDLE;
      CLEAR:   state_n = INTEG;
      INTEG:   state_n = stop ? IDLE : (cnt == osr_q - CNT_W'(1)) ? DUMP : INTEG;
      DUMP:    state_n = CAPTURE;
      CAPTURE: state_n = (cont && !stop) ? INTEG : IDLE;
      default: state_n = IDLE;
    endcase
    // the CAPTURE cycle already counts as window cycle 0 of the next conversion
    if (state_n == INTEG)
      cnt_n = (state == INTEG) ? cnt + CNT_W'(1) : cap ? CNT_W'(1) : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      osr_q        <= CNT_W'(2);
      filt_rst     <= 1'b0;
      result_data  <= '0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
      conv_count   <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      filt_rst <= (state_n == CLEAR) || (state_n == DUMP);
      if (state == IDLE && state_n == CLEAR) osr_q <= osr_clamped;
      if (cap) begin
        result_data <= filt_z;
        conv_count  <= conv_count + CONV_CNT_W'(1);
      end
      result_valid <= cap | (result_valid & ~result_ready);
      // a fresh overrun outranks a simultaneous clear
      overrun <= (cap & result_valid & ~result_ready) | (overrun & ~clr_ovr);
    end
  end
endmodule

// File: tb/tb_dsm_conv_sequencer.sv
// tb_dsm_conv_sequencer: scoreboard bench with directed conversions for dsm_conv_sequencer
module tb_dsm_conv_sequencer;
  logic clk = 0, rst_n = 0, start = 0, cont = 0, stop = 0, result_ready = 0, clr_ovr = 0;
  logic [9:0] osr_in = 0;
  logic [15:0] const_z = 0, z_base = 0, inc_z = 0, filt_z;
  logic inc_mode = 0;
  logic filt_rst, filt_type_dec, result_valid, overrun, busy;
  logic [15:0] result_data;
  logic [7:0] conv_count;
  int checks = 0, errors = 0;
  logic [15:0] exp_q[$];

  dsm_conv_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .stop(stop), .osr_in(osr_in),
    .filt_z(filt_z), .filt_rst(filt_rst), .filt_type_dec(filt_type_dec),
    .result_data(result_data), .result_valid(result_valid), .result_ready(result_ready),
    .overrun(overrun), .clr_ovr(clr_ovr), .busy(busy), .conv_count(conv_count)
  );

  always #5 clk = ~clk;

  // filter stub: Z steps once per filter reset pulse
  assign filt_z = inc_mode ? inc_z : const_z;
  always @(posedge clk) inc_z <= !inc_mode ? z_base : filt_rst ? inc_z + 16'd1 : inc_z;

  always @(negedge clk) begin
    if (rst_n && result_valid && result_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL result_unexpected got %h exp none", result_data);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (result_data !== e) begin
          errors++;
          $display("FAIL result_data got %h exp %h", result_data, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, act, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1;
    tick();
    start = 0;
  endtask

  // samples filt_rst in cycles 1..n after the start edge; ends at cycle n+1
  task automatic pattern(input string nm, input int n, input logic [63:0] expv, input int drop);
    int bad = 0;
    for (int c = 1; c <= n; c++) begin
      if (filt_rst !== expv[c]) bad++;
      if (c == drop) cont = 0;
      tick();
    end
    chk(nm, bad, 0);
  endtask

  task automatic do_reset();
    rst_n = 0;
    tick();
    rst_n = 1;
    tick();
  endtask

  initial begin
    tick(); tick();
    chk("rst_filt_rst", filt_rst, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_count", conv_count, 0);
    chk("rst_data", result_data, 0);
    chk("type_dec", filt_type_dec, 0);
    rst_n = 1;
    tick();

    // single conversion, osr 16; osr_in change mid-conversion must not matter
    osr_in = 16; const_z = 16'h0078;
    pulse_start();
    osr_in = 3;
    pattern("single_filt_rst", 19, (64'd1 << 1) | (64'd1 << 18), 0);
    chk("single_valid", result_valid, 1);
    chk("single_data", result_data, 16'h0078);
    chk("single_busy", busy, 0);
    chk("single_count", conv_count, 1);
    exp_q.push_back(16'h0078);
    result_ready = 1;
    tick();
    chk("single_drained", result_valid, 0);

    // asynchronous reset mid-INTEG
    osr_in = 16;
    pulse_start();
    tick(); tick(); tick();
    #2 rst_n = 0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_filt_rst", filt_rst, 0);
    chk("arst_count", conv_count, 0);
    chk("arst_data", result_data, 0);
    tick();
    rst_n = 1;
    tick();

    // continuous, prompt reads
    z_base = 16'h0100; inc_mode = 0;
    tick();
    inc_mode = 1; osr_in = 8; cont = 1; result_ready = 1;
    for (int i = 2; i <= 6; i++) exp_q.push_back(16'h0100 + 16'(i));
    pulse_start();
    pattern("cont_filt_rst", 47, (64'd1 << 1) | (64'd1 << 10) | (64'd1 << 19) | (64'd1 << 28) |
            (64'd1 << 37) | (64'd1 << 46), 46);
    tick(); tick();
    chk("cont_queue_empty", exp_q.size(), 0);
    chk("cont_count", conv_count, 5);
    chk("cont_overrun", overrun, 0);
    chk("cont_busy", busy, 0);

    // overrun, osr 4, no reads
    do_reset();
    inc_mode = 0; z_base = 16'h0200; result_ready = 0;
    tick();
    inc_mode = 1; osr_in = 4; cont = 1;
    pulse_start();
    repeat (7) tick();
    chk("ovr_first_valid", result_valid, 1);
    chk("ovr_first_data", result_data, 16'h0202);
    chk("ovr_first_flag", overrun, 0);
    repeat (5) tick();
    chk("ovr_second_data", result_data, 16'h0203);
    chk("ovr_second_flag", overrun, 1);
    clr_ovr = 1;
    tick();
    clr_ovr = 0;
    chk("ovr_cleared", overrun, 0);
    repeat (3) tick();
    clr_ovr = 1;
    tick();
    clr_ovr = 0;
    chk("ovr_set_wins", overrun, 1);
    chk("ovr_third_data", result_data, 16'h0204);
    cont = 0;
    repeat (5) tick();
    chk("ovr_idle", busy, 0);
    chk("ovr_sticky", overrun, 1);
    chk("ovr_count", conv_count, 4);
    exp_q.push_back(16'h0205);
    result_ready = 1;
    tick();
    chk("ovr_drained", result_valid, 0);

    // abort in INTEG at cnt 5
    inc_mode = 0; osr_in = 16;
    pulse_start();
    repeat (6) tick();
    stop = 1;
    tick();
    stop = 0;
    chk("abort_busy", busy, 0);
    tick();
    chk("abort_valid", result_valid, 0);
    chk("abort_count", conv_count, 4);

    // start together with stop is ignored
    start = 1; stop = 1;
    tick();
    start = 0; stop = 0;
    chk("start_stop_busy", busy, 0);

    // osr 0 clamps to 2
    osr_in = 0; const_z = 16'h0abc;
    exp_q.push_back(16'h0abc);
    pulse_start();
    pattern("clamp_filt_rst", 5, (64'd1 << 1) | (64'd1 << 4), 0);
    chk("clamp_count", conv_count, 5);
    chk("clamp_busy", busy, 0);
    tick();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dsm_conv_sequencer.md
Name: dsm_conv_sequencer

Overview:
- Conversion controller that drives the 1-bit delta-sigma decimation filter in incremental (Type 1) mode.
- Generates the filter's dump/clear reset pulses at a programmable oversampling ratio (OSR) and captures the decimated word.
- Presents each result to downstream logic over a valid/ready handshake and flags overruns.
- Sits between the modulator bitstream path and the tile output register.

Parameters:
- OUTPUT_BITS, 16, width of filter output word and result_data.
- CNT_W, 10, width of OSR counter and osr_in.
- CONV_CNT_W, 8, width of the completed-conversion counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin conversion(s); sampled in IDLE only.
- cont  in  1  1 = back-to-back conversions; 0 = single conversion.
- stop  in  1  abort request.
- osr_in  in  CNT_W  OSR; latched at start; values below 2 are treated as 2.
- filt_z  in  OUTPUT_BITS  filter Z output.
- filt_rst  out  1  registered reset pulse to the filter (active high).
- filt_type_dec  out  1  tied 0 (incremental mode).
- result_data  out  OUTPUT_BITS  captured conversion result.
- result_valid  out  1  result available.
- result_ready  in  1  downstream accepts the result.
- overrun  out  1  sticky flag: an unread result was overwritten.
- clr_ovr  in  1  clears overrun.
- busy  out  1  high in any state other than IDLE.
- conv_count  out  CONV_CNT_W  completed conversions; wraps.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, cnt=0, osr_q=2, filt_rst=0, result_data=0, result_valid=0, overrun=0, conv_count=0. busy=0 follows from IDLE.
- State names are fixed: IDLE, CLEAR, INTEG, DUMP, CAPTURE. filt_rst is a registered output, high only in CLEAR and DUMP.
- IDLE: start=1 at a clock edge latches osr_q=max(osr_in,2) and goes to CLEAR. If stop=1 in the same cycle, start is ignored.
- CLEAR (1 cycle): filt_rst=1 to flush the filter integrators. Goes to INTEG with cnt=0.
- INTEG: filt_rst=0; cnt increments every cycle.
  - When cnt==osr_q-1, go to DUMP. The integration window is exactly osr_q cycles with filt_rst low.
  - stop=1 goes to IDLE at the next edge; no result is produced.
- DUMP (1 cycle): filt_rst=1. The filter loads Z and clears its integrators. Goes to CAPTURE; stop is ignored.
- CAPTURE (1 cycle): filt_rst=0. On the exit edge: result_data<=filt_z, result_valid<=1, conv_count<=conv_count+1.
  - If cont=1 and stop=0: go to INTEG with cnt=1. The CAPTURE cycle counts as window cycle 0 of the next conversion.
  - Otherwise go to IDLE.
- filt_rst always has at least one low cycle between pulses, so the filter's edge detection never misses a pulse.
- Timing: result_valid rises osr_q+3 edges after the start edge. Continuous result period is osr_q+1 cycles.
- Handshake:
  - result_valid stays high and result_data stays stable until result_ready=1 at an edge; that edge clears result_valid.
  - Capture with result_valid=1 and result_ready=0: data is overwritten, valid stays 1, overrun<=1.
  - Capture with result_ready=1 in the same cycle: new data, valid stays 1, no overrun.
- overrun: cleared by clr_ovr=1. If an overrun-set and clr_ovr occur in the same cycle, set wins.
- osr_in changes during a conversion have no effect until the next start.
- cnt never exceeds osr_q-1. conv_count wraps from 2^CONV_CNT_W-1 to 0.

Test Plan:
- Reset/idle: rst_n=0 mid-INTEG -> all outputs return to reset values immediately (asynchronous); filt_rst=0 and busy=0.
- Single conversion: osr_in=16, cont=0, stub filt_z=16'h0078, start pulse at edge 0.
  - filt_rst is high during cycle 1, low for cycles 2-17, and high during cycle 18.
  - result_valid=1 with result_data=16'h0078 after edge 19; busy=0 afterwards; conv_count=1.
- Continuous with prompt reads: osr_in=8, cont=1, result_ready=1, filt_z incrementing stub.
  - filt_rst pulses every 9 cycles; 5 results are captured in order.
  - overrun stays 0; conv_count=5.
- Overrun: continuous, osr_in=4, result_ready=0.
  - Second capture sets overrun=1 and result_data holds the second value.
  - clr_ovr pulse -> overrun=0; a later overrun-set coinciding with clr_ovr -> overrun=1.
- Abort and clamp:
  - stop=1 at INTEG cycle 5 -> IDLE next edge, no result_valid, conv_count unchanged.
  - osr_in=0 -> exactly 2 low filt_rst cycles between the CLEAR and DUMP pulses.
